// File: rtl/sensor_pkg.sv
// Shared types and constants for the sensor front-end pipeline.
package sensor_pkg;

    typedef logic [7:0] sample_word_t;

    typedef enum logic {
        WAIT_FIRST,
        RUN
    } edge_fsm_t;

    localparam int unsigned SAMPLES_PER_WORD = 8;

endpackage

// File: rtl/rise_prio_enc8.sv
// Lowest-position rising-edge finder for one 8-sample word.
module rise_prio_enc8
    import sensor_pkg::*;
(
    input  logic         prev_bit,
    input  sample_word_t IN,
    output logic         found,
    output logic [2:0]   pos
);

    logic [SAMPLES_PER_WORD:0] s;

    // s[0] is the last sample of the previous word, so position 0 spans the word boundary
    assign s = {IN, prev_bit};

    // Scan upwards and keep only the first rising edge
    always_comb begin
        found = 1'b0;
        pos   = '0;
        for (int unsigned i = 0; i < SAMPLES_PER_WORD; i++) begin
            if (!found && s[i+1] && !s[i]) begin
                found = 1'b1;
                pos   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/edge_period_meter.sv
// Rising-edge period meter for 8x-oversampled deserializer words.
module edge_period_meter
    import sensor_pkg::*;
#(
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned MIN_PERIOD    = 16,
    parameter int unsigned TIMEOUT_WORDS = 4000
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               CE,
    input  sample_word_t       IN,
    output logic [CNT_W+2:0]   PERIOD_OUT,
    output logic               PERIOD_VALID,
    output logic [2:0]         EDGE_POS,
    output logic               NO_SIGNAL
);

    localparam int unsigned TS_W = CNT_W + 3;

    // stage 1
    logic [CNT_W-1:0] word_cnt;
    logic             prev_bit;
    logic             s1_full;
    logic             s1_cand;
    logic [TS_W-1:0]  s1_ts;
    logic             enc_found;
    logic [2:0]       enc_pos;

    // stage 2
    edge_fsm_t        state, state_nxt;
    logic [TS_W-1:0]  last_ts, last_ts_nxt;
    logic [CNT_W-1:0] idle_cnt, idle_nxt;
    logic [CNT_W:0]   idle_inc;
    logic [TS_W-1:0]  diff;
    logic             accept;
    logic             no_sig_nxt;

    rise_prio_enc8 u_enc (
        .prev_bit (prev_bit),
        .IN       (IN),
        .found    (enc_found),
        .pos      (enc_pos)
    );

    // Stage 1: register candidate and its timestamp for each consumed word
    always_ff @(posedge CLK) begin
        if (RESET) begin
            word_cnt <= '0;
            prev_bit <= 1'b0;
            s1_full  <= 1'b0;
            s1_cand  <= 1'b0;
            s1_ts    <= '0;
        end else if (CE) begin
            word_cnt <= word_cnt + 1'b1;
            prev_bit <= IN[7];
            s1_full  <= 1'b1;
            s1_cand  <= enc_found;
            s1_ts    <= {word_cnt, enc_pos};
        end
    end

    assign diff     = s1_ts - last_ts;
    assign idle_inc = {1'b0, idle_cnt} + 1'b1;

    // Stage 2 next-state: acceptance, glitch rejection and timeout; a candidate beats the timeout
    always_comb begin
        state_nxt   = state;
        last_ts_nxt = last_ts;
        idle_nxt    = idle_cnt;
        no_sig_nxt  = NO_SIGNAL;
        accept      = 1'b0;
        if (CE && s1_full) begin
            unique case (state)
                WAIT_FIRST: begin
                    if (s1_cand) begin
                        last_ts_nxt = s1_ts;
                        no_sig_nxt  = 1'b0;
                        idle_nxt    = '0;
                        state_nxt   = RUN;
                    end
                end
                RUN: begin
                    if (s1_cand && diff >= TS_W'(MIN_PERIOD)) begin
                        accept      = 1'b1;
                        last_ts_nxt = s1_ts;
                        idle_nxt    = '0;
                    end else if (idle_inc >= (CNT_W+1)'(TIMEOUT_WORDS)) begin
                        idle_nxt    = '0;
                        no_sig_nxt  = 1'b1;
                        state_nxt   = WAIT_FIRST;
                    end else begin
                        idle_nxt    = idle_inc[CNT_W-1:0];
                    end
                end
                default: state_nxt = WAIT_FIRST;
            endcase
        end
    end

    // Stage 2 registers and outputs; PERIOD_VALID is a single-cycle strobe
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= WAIT_FIRST;
            last_ts      <= '0;
            idle_cnt     <= '0;
            PERIOD_OUT   <= '0;
            PERIOD_VALID <= 1'b0;
            EDGE_POS     <= '0;
            NO_SIGNAL    <= 1'b1;
        end else begin
            state        <= state_nxt;
            last_ts      <= last_ts_nxt;
            idle_cnt     <= idle_nxt;
            NO_SIGNAL    <= no_sig_nxt;
            PERIOD_VALID <= accept;
            if (accept) begin
                PERIOD_OUT <= diff;
                EDGE_POS   <= s1_ts[2:0];
            end
        end
    end

endmodule

// File: tb/tb_edge_period_meter.sv
// Directed plus randomized bench for edge_period_meter with a sample-level reference model.
module tb_edge_period_meter;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned MIN_P = 16;
    localparam int unsigned TMO   = 200;
    localparam int unsigned TS_W  = CNT_W + 3;

    logic            CLK = 1'b0;
    logic            RESET;
    logic            CE;
    logic [7:0]      IN;
    logic [TS_W-1:0] PERIOD_OUT;
    logic            PERIOD_VALID;
    logic [2:0]      EDGE_POS;
    logic            NO_SIGNAL;

    edge_period_meter #(
        .CNT_W         (CNT_W),
        .MIN_PERIOD    (MIN_P),
        .TIMEOUT_WORDS (TMO)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .CE           (CE),
        .IN           (IN),
        .PERIOD_OUT   (PERIOD_OUT),
        .PERIOD_VALID (PERIOD_VALID),
        .EDGE_POS     (EDGE_POS),
        .NO_SIGNAL    (NO_SIGNAL)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int n_strobe = 0;
    int dir_period = 0;
    int ph = 0;

    // reference model: absolute sample positions, plain arithmetic
    bit      m_track, m_prev, m_nosig;
    longint  m_last;
    longint  m_w;
    int      m_idle;
    // result of the last consumed word, visible after the next consumed word
    bit      p_has, p_accept, p_nosig;
    int      p_period, p_pos;
    // expected visible outputs
    bit      e_valid, e_nosig;
    int      e_period, e_pos;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_track = 0; m_prev = 0; m_nosig = 1; m_last = 0; m_w = 0; m_idle = 0;
        p_has = 0; p_accept = 0; p_nosig = 1; p_period = 0; p_pos = 0;
        e_valid = 0; e_nosig = 1; e_period = 0; e_pos = 0;
    endtask

    task automatic model_word(input logic [7:0] w);
        bit found = 0;
        int pos = 0;
        bit prv;
        longint abs_pos;
        for (int i = 0; i < 8; i++) begin
            prv = (i == 0) ? m_prev : w[i-1];
            if (!found && w[i] && !prv) begin
                found = 1;
                pos = i;
            end
        end
        m_prev = w[7];
        abs_pos = m_w * 8 + pos;
        m_w++;
        p_has = 1;
        p_accept = 0;
        if (!m_track) begin
            if (found) begin
                m_track = 1; m_last = abs_pos; m_idle = 0; m_nosig = 0;
            end
        end else if (found && (abs_pos - m_last) >= MIN_P) begin
            p_accept = 1;
            p_period = int'(abs_pos - m_last);
            p_pos = pos;
            m_last = abs_pos;
            m_idle = 0;
        end else begin
            m_idle++;
            if (m_idle >= TMO) begin
                m_track = 0; m_nosig = 1; m_idle = 0;
            end
        end
        p_nosig = m_nosig;
    endtask

    task automatic step(input bit rst, input bit ce, input logic [7:0] w);
        RESET = rst; CE = ce; IN = w;
        @(posedge CLK);
        #1;
        if (rst) begin
            model_reset();
        end else if (ce) begin
            e_valid = p_has && p_accept;
            if (e_valid) begin
                e_period = p_period;
                e_pos = p_pos;
            end
            if (p_has) e_nosig = p_nosig;
            model_word(w);
        end else begin
            e_valid = 0;
        end
        chk("PERIOD_VALID", 32'(PERIOD_VALID), 32'(e_valid));
        chk("NO_SIGNAL", 32'(NO_SIGNAL), 32'(e_nosig));
        chk("PERIOD_OUT", 32'(PERIOD_OUT), 32'(e_period));
        chk("EDGE_POS", 32'(EDGE_POS), 32'(e_pos));
        if (PERIOD_VALID === 1'b1) begin
            n_strobe++;
            if (dir_period != 0) chk("directed_period", 32'(PERIOD_OUT), 32'(dir_period));
        end
    endtask

    // square wave starting low: lo samples 0, hi samples 1; optional CE=0 gap
    task automatic wave(input int lo, input int hi, input int nwords, input int gap_at, input int gap_len);
        logic [7:0] w;
        for (int k = 0; k < nwords; k++) begin
            if (k == gap_at)
                for (int g = 0; g < gap_len; g++) step(0, 0, 8'($urandom));
            for (int b = 0; b < 8; b++) begin
                w[b] = (ph % (lo + hi)) >= lo;
                ph++;
            end
            step(0, 1, w);
        end
    endtask

    initial begin
        model_reset();
        RESET = 1; CE = 0; IN = '0;

        // reset state
        step(1, 1, 8'hFF);
        chk("reset_no_signal", 32'(NO_SIGNAL), 32'd1);
        chk("reset_period", 32'(PERIOD_OUT), 32'd0);
        step(0, 1, 8'h00);
        chk("post_reset_no_strobe", 32'(PERIOD_VALID), 32'd0);

        // 10/10 square wave: 16 edges, 15 strobes of 20
        step(1, 0, 8'h00);
        ph = 0; n_strobe = 0; dir_period = 20;
        wave(10, 10, 40, -1, 0);
        step(0, 1, 8'h00);
        step(0, 1, 8'h00);
        chk("square_strobes", 32'(n_strobe), 32'd15);
        dir_period = 0;

        // first edge at position 0 in WAIT_FIRST
        step(1, 0, 8'h00);
        step(0, 1, 8'h00);
        step(0, 1, 8'h01);
        chk("first_edge_nosig_hold", 32'(NO_SIGNAL), 32'd1);
        step(0, 1, 8'h00);
        chk("first_edge_nosig_fall", 32'(NO_SIGNAL), 32'd0);
        chk("first_edge_no_strobe", 32'(PERIOD_VALID), 32'd0);
        chk("first_edge_pos", 32'(EDGE_POS), 32'd0);

        // multiple edges in a word, glitch rejection, then period 24
        step(1, 0, 8'h00);
        n_strobe = 0; dir_period = 24;
        step(0, 1, 8'h00);
        step(0, 1, 8'b0000_1001);
        step(0, 1, 8'b0001_0000);
        step(0, 1, 8'h00);
        step(0, 1, 8'h01);
        step(0, 1, 8'h00);
        step(0, 1, 8'h00);
        chk("glitch_strobes", 32'(n_strobe), 32'd1);
        dir_period = 0;

        // timeout on constant 0, then recovery needs two edges
        for (int k = 0; k < int'(TMO) + 2; k++) step(0, 1, 8'h00);
        chk("timeout_zero", 32'(NO_SIGNAL), 32'd1);
        ph = 0; n_strobe = 0; dir_period = 20;
        wave(10, 10, 8, -1, 0);
        step(0, 1, 8'h00);
        step(0, 1, 8'h00);
        chk("recover_strobes", 32'(n_strobe), 32'd2);
        dir_period = 0;

        // timeout on constant 1
        step(0, 1, 8'hFF);
        for (int k = 0; k < int'(TMO) + 3; k++) step(0, 1, 8'hFF);
        chk("timeout_one", 32'(NO_SIGNAL), 32'd1);

        // period 40 with a 5-cycle CE gap
        step(1, 0, 8'h00);
        ph = 0; n_strobe = 0; dir_period = 40;
        wave(20, 20, 30, 12, 5);
        step(0, 1, 8'h00);
        step(0, 1, 8'h00);
        chk("ce_gap_strobes", 32'(n_strobe), 32'd5);
        dir_period = 0;

        // reset with an edge in flight
        step(0, 1, 8'h00);
        step(0, 1, 8'h01);
        step(1, 1, 8'h00);
        chk("reset_inflight_valid", 32'(PERIOD_VALID), 32'd0);
        chk("reset_inflight_nosig", 32'(NO_SIGNAL), 32'd1);
        n_strobe = 0;
        step(0, 1, 8'h00);
        step(0, 1, 8'h01);
        step(0, 1, 8'h00);
        step(0, 1, 8'h00);
        step(0, 1, 8'h01);
        step(0, 1, 8'h00);
        step(0, 1, 8'h00);
        chk("reset_fresh_strobes", 32'(n_strobe), 32'd1);
        chk("reset_fresh_period", 32'(PERIOD_OUT), 32'd24);

        // randomized segments: waves, noise, CE gaps, occasional reset
        for (int seg = 0; seg < 60; seg++) begin
            int mode = int'($urandom_range(0, 9));
            if (mode == 0) begin
                step(1, 1, 8'($urandom));
            end else if (mode <= 2) begin
                for (int k = 0; k < 20; k++)
                    step(0, $urandom_range(0, 7) != 0, 8'($urandom));
            end else begin
                int lo = int'($urandom_range(1, 40));
                int hi = int'($urandom_range(1, 40));
                int nw = int'($urandom_range(5, 60));
                wave(lo, hi, nw, int'($urandom_range(0, nw)), int'($urandom_range(0, 6)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
